// File: rtl/lau_pkg.sv
// Shared LAU types: comparator speed selection and the min/max stage states.
package lau_pkg;

    typedef enum logic {
        SMALL,
        FAST
    } speed_e;

    typedef enum logic [1:0] {
        EMPTY,
        ACC,
        HOLD
    } minmax_state_e;

endpackage

// File: rtl/cmp_stream_minmax_cmp.sv
// CmpEQGE: unsigned equal / greater-or-equal comparator.
// FAST uses a flat magnitude compare; SMALL uses an LSB-to-MSB ripple chain.
module CmpEQGE
    import lau_pkg::*;
#(
    parameter int     width = 8,
    parameter speed_e speed = FAST
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             EQ,
    output logic             GE
);

    assign EQ = (A == B);

    generate
        if (speed == FAST) begin : g_fast
            assign GE = (A >= B);
        end else begin : g_small
            logic ge_r;
            // Ripple: a higher bit that differs decides, otherwise the lower result carries up.
            always_comb begin
                ge_r = 1'b1;
                for (int i = 0; i < width; i++) begin
                    ge_r = (A[i] & ~B[i]) | (~(A[i] ^ B[i]) & ge_r);
                end
            end
            assign GE = ge_r;
        end
    endgenerate

endmodule

// File: rtl/cmp_stream_minmax.sv
// cmp_stream_minmax: per-packet running max/min, element count and all-equal
// tracking over valid/ready streams.
// Optional macro LAU_MINMAX_INDEX_EN adds OutMaxIdx/OutMinIdx (first-occurrence
// positions of the extremes).
//
// state | meaning
// EMPTY | no element of the current packet accepted yet
// ACC   | packet in progress, accumulating extremes
// HOLD  | packet complete, result presented on the output
module cmp_stream_minmax
    import lau_pkg::*;
#(
    parameter int     width    = 8,
    parameter int     cntWidth = 16,
    parameter bit     signed_  = 1'b0,
    parameter speed_e speed    = FAST
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Clr,
    input  logic                InValid,
    output logic                InReady,
    input  logic [width-1:0]    InData,
    input  logic                InLast,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [width-1:0]    OutMax,
    output logic [width-1:0]    OutMin,
    output logic [cntWidth-1:0] OutCount,
    output logic                OutAllEq,
`ifdef LAU_MINMAX_INDEX_EN
    output logic [cntWidth-1:0] OutMaxIdx,
    output logic [cntWidth-1:0] OutMinIdx,
`endif
    output logic                OutSat
);

    minmax_state_e       state_q, state_d;
    logic [width-1:0]    max_q, max_d, min_q, min_d;
    logic [cntWidth-1:0] cnt_q, cnt_d;
    logic                alleq_q, alleq_d, sat_q, sat_d;
`ifdef LAU_MINMAX_INDEX_EN
    logic [cntWidth-1:0] maxidx_q, maxidx_d, minidx_q, minidx_d;
`endif

    logic [width-1:0] cmp_in, cmp_max, cmp_min;
    logic             eq_max, ge_max, eq_min, ge_min;
    logic             accept, cnt_full;

    // Flipping the MSB maps two's-complement order onto unsigned order.
    assign cmp_in  = signed_ ? {~InData[width-1], InData[width-2:0]} : InData;
    assign cmp_max = signed_ ? {~max_q[width-1],  max_q[width-2:0]}  : max_q;
    assign cmp_min = signed_ ? {~min_q[width-1],  min_q[width-2:0]}  : min_q;

    CmpEQGE #(.width(width), .speed(speed)) u_cmp_max (
        .A (cmp_in),
        .B (cmp_max),
        .EQ(eq_max),
        .GE(ge_max)
    );

    CmpEQGE #(.width(width), .speed(speed)) u_cmp_min (
        .A (cmp_in),
        .B (cmp_min),
        .EQ(eq_min),
        .GE(ge_min)
    );

    assign InReady  = (state_q != HOLD);
    assign OutValid = (state_q == HOLD);
    assign accept   = InValid && InReady;
    assign cnt_full = &cnt_q;

    // Next-state and datapath update; Clr wins over any handshake.
    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        alleq_d = alleq_q;
        sat_d   = sat_q;
`ifdef LAU_MINMAX_INDEX_EN
        maxidx_d = maxidx_q;
        minidx_d = minidx_q;
`endif
        if (Clr) begin
            state_d = EMPTY;
            max_d   = '0;
            min_d   = '0;
            cnt_d   = '0;
            alleq_d = 1'b0;
            sat_d   = 1'b0;
`ifdef LAU_MINMAX_INDEX_EN
            maxidx_d = '0;
            minidx_d = '0;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        max_d   = InData;
                        min_d   = InData;
                        cnt_d   = cntWidth'(1);
                        alleq_d = 1'b1;
                        sat_d   = 1'b0;
`ifdef LAU_MINMAX_INDEX_EN
                        maxidx_d = '0;
                        minidx_d = '0;
`endif
                        state_d = InLast ? HOLD : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        // Strictly greater / strictly less so ties keep the earlier element.
                        if (ge_max && !eq_max) begin
                            max_d = InData;
`ifdef LAU_MINMAX_INDEX_EN
                            if (!sat_q) maxidx_d = cnt_q;
`endif
                        end
                        if (!ge_min) begin
                            min_d = InData;
`ifdef LAU_MINMAX_INDEX_EN
                            if (!sat_q) minidx_d = cnt_q;
`endif
                        end
                        // While alleq holds max==min, so checking both is equivalent to max alone.
                        alleq_d = alleq_q & eq_max & eq_min;
                        if (cnt_full) sat_d = 1'b1;
                        else          cnt_d = cnt_q + cntWidth'(1);
                        state_d = InLast ? HOLD : ACC;
                    end
                end
                HOLD: begin
                    if (OutReady) state_d = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= EMPTY;
            max_q   <= '0;
            min_q   <= '0;
            cnt_q   <= '0;
            alleq_q <= 1'b0;
            sat_q   <= 1'b0;
`ifdef LAU_MINMAX_INDEX_EN
            maxidx_q <= '0;
            minidx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
            alleq_q <= alleq_d;
            sat_q   <= sat_d;
`ifdef LAU_MINMAX_INDEX_EN
            maxidx_q <= maxidx_d;
            minidx_q <= minidx_d;
`endif
        end
    end

    assign OutMax   = max_q;
    assign OutMin   = min_q;
    assign OutCount = cnt_q;
    assign OutAllEq = alleq_q;
    assign OutSat   = sat_q;
`ifdef LAU_MINMAX_INDEX_EN
    assign OutMaxIdx = maxidx_q;
    assign OutMinIdx = minidx_q;
`endif

endmodule
